act_line_writer: RTL and testbench
==================================

ACT_LINE_WRITER -- requirements
Module: act_line_writer

Interface
REQ-001 SHALL have parameter writeInterfaceWidth, default 32, width of one incoming data word.
REQ-002 SHALL have parameter writeAddrWidth, default 16, incoming word-address width.
REQ-003 SHALL have parameter sramDataWidth, default 128, SRAM line width; WPL = sramDataWidth/writeInterfaceWidth, power of two, at least 2.
REQ-004 SHALL have parameter sramAddrWidth, default writeAddrWidth - log2(WPL), SRAM line-address width.
REQ-005 SHALL have ports:
- clk  input  1  sole clock, rising edge
- nrst  input  1  asynchronous active-low reset
- in_addr  input  writeAddrWidth  word address of incoming write
- in_data  input  writeInterfaceWidth  incoming write data
- in_valid  input  1  incoming write valid
- in_ready  output  1  write accepted when in_valid and in_ready are both high
- flush  input  1  force the held partial line to SRAM
- rd_req  input  1  SRAM read request
- rd_addr  input  sramAddrWidth  read line address
- rd_grant  output  1  read issued to SRAM this cycle
- sram_en  output  1  SRAM access enable
- sram_we  output  1  1 = write, 0 = read
- sram_addr  output  sramAddrWidth  SRAM line address
- sram_wdata  output  sramDataWidth  write line data
- sram_wmask  output  WPL  per-word write enable
- busy  output  1  high when state is not IDLE

Function
REQ-006 SHALL split in_addr into line = in_addr[writeAddrWidth-1:log2(WPL)] and word = in_addr[log2(WPL)-1:0].
REQ-007 SHALL hold one line buffer: line address, WPL data words, and a WPL-bit mask; word w maps to bits [w*writeInterfaceWidth +: writeInterfaceWidth] and mask bit w.
REQ-008 SHALL implement a 3-state FSM: IDLE, FILL, WRITE.
REQ-009 In IDLE, SHALL drive in_ready=1; on accept, SHALL load line address, store the word, set its mask bit, and go to FILL. If WPL=1-word line completion occurs, the FILL-to-WRITE rule applies.
REQ-010 In FILL, SHALL drive in_ready=1 when in_valid is low or the incoming line equals the held line, and 0 otherwise.
REQ-011 In FILL, on accept SHALL write the word and set its mask bit; a repeat write to a set word SHALL overwrite the data.
REQ-012 SHALL go FILL->WRITE on the next edge when:
- the mask becomes all-ones, or
- flush=1, or
- in_valid=1 with a different line.
The rejected word SHALL be held by the source and accepted in IDLE afterward.
REQ-013 In WRITE, SHALL drive in_ready=0.
REQ-014 In WRITE, in a cycle with no granted read, SHALL drive sram_en=1, sram_we=1, sram_addr=held line, sram_wdata=line data, and sram_wmask=mask; it SHALL then clear the mask and go to IDLE on the next edge.
REQ-015 Masked-off words of sram_wdata SHALL be don't-care; sram_wmask SHALL be 0 whenever sram_we=0.
REQ-016 In IDLE, SHALL treat flush as a no-op.
REQ-017 SHALL grant reads combinationally: rd_grant=rd_req unless there is a hazard, where hazard = (state is FILL or WRITE) and rd_addr equals the held line.
REQ-018 On a grant, SHALL drive sram_en=1, sram_we=0, sram_addr=rd_addr; a granted read SHALL take priority over a WRITE-state write, which waits.
REQ-019 On a hazard in FILL, SHALL force a transition to WRITE (as if flush=1).
REQ-020 On a hazard in WRITE, SHALL issue the write that cycle with rd_grant=0; the read SHALL be granted from the following cycle.
REQ-021 With no read and no write pending, SHALL drive sram_en=0.
REQ-022 Latency: WPL consecutive words to one line accepted in cycles 0..WPL-1 SHALL produce the SRAM write in cycle WPL when rd_req=0, with in_ready=0 in cycle WPL and 1 in cycle WPL+1.

Reset
REQ-023 While nrst=0 (asynchronous), SHALL set state=IDLE, mask=0, and line address and data to 0.
REQ-024 During and after reset, outputs SHALL be: sram_en=0, sram_we=0, sram_wmask=0, busy=0, in_ready=1, rd_grant=rd_req.
REQ-025 On reset assertion mid-FILL or mid-WRITE, SHALL discard pending data with no SRAM write issued.

Verification
REQ-026 SHALL verify the full line: WPL=4, words at addrs 0x10..0x13 with data A..D on cycles 0-3 -> cycle 4: sram_we=1, sram_addr=0x4, sram_wmask=4'b1111, sram_wdata={D,C,B,A}; busy=0 at cycle 5.
REQ-027 SHALL verify a line change: 0x10, 0x11, then 0x20 -> in_ready=0 for 0x20; write of line 0x4 with mask 4'b0011; 0x20 accepted in IDLE on the following cycle.
REQ-028 SHALL verify read priority: WRITE state pending with rd_req=1 to line 0x9 for 3 cycles -> rd_grant=1 for 3 cycles, no write issued; write issued in cycle 4.
REQ-029 SHALL verify the read hazard: held line 0x4 in FILL with mask 4'b0001, rd_req to line 0x4 -> rd_grant=0, write mask 4'b0001 issued, then rd_grant=1.
REQ-030 SHALL verify flush and overwrite: addr 0x12 data X then 0x12 data Y, then flush -> write of line 0x4 with mask 4'b0100 and word 2 = Y; flush in IDLE -> sram_en=0.
REQ-031 SHALL verify reset mid-FILL: nrst pulsed low after 2 accepted words -> no SRAM write, busy=0, mask=0, in_ready=1.

Source files
------------

// File: rtl/act_line_writer.sv
// Write-combining line buffer: packs narrow incoming words into one SRAM line
// and shares the single-port SRAM with a read path that has priority.
module act_line_writer #(
    parameter int writeInterfaceWidth = 32,
    parameter int writeAddrWidth      = 16,
    parameter int sramDataWidth       = 128,
    parameter int sramAddrWidth       = writeAddrWidth - $clog2(sramDataWidth / writeInterfaceWidth)
) (
    input  logic                                          clk,
    input  logic                                          nrst,
    input  logic [writeAddrWidth-1:0]                     in_addr,
    input  logic [writeInterfaceWidth-1:0]                in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic                                          flush,
    input  logic                                          rd_req,
    input  logic [sramAddrWidth-1:0]                      rd_addr,
    output logic                                          rd_grant,
    output logic                                          sram_en,
    output logic                                          sram_we,
    output logic [sramAddrWidth-1:0]                      sram_addr,
    output logic [sramDataWidth-1:0]                      sram_wdata,
    output logic [sramDataWidth/writeInterfaceWidth-1:0]  sram_wmask,
    output logic                                          busy
);

    localparam int WPL = sramDataWidth / writeInterfaceWidth;
    localparam int WB  = $clog2(WPL);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                   state_q, state_d;
    logic [sramAddrWidth-1:0] line_q, line_d;
    logic [sramDataWidth-1:0] data_q, data_d;
    logic [WPL-1:0]           mask_q, mask_d;

    logic [sramAddrWidth-1:0] in_line;
    logic [WB-1:0]            in_word;
    logic                     same_line;
    logic                     hazard;

    assign in_line   = in_addr[writeAddrWidth-1:WB];
    assign in_word   = in_addr[WB-1:0];
    assign same_line = (in_line == line_q);
    // A read to the line still being assembled must wait until that line is in SRAM.
    assign hazard    = rd_req && (state_q != IDLE) && (rd_addr == line_q);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        data_d     = data_q;
        mask_d     = mask_q;
        in_ready   = 1'b0;
        rd_grant   = rd_req && !hazard;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = rd_addr;
        sram_wdata = data_q;
        sram_wmask = '0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    line_d = in_line;
                    data_d[int'(in_word)*writeInterfaceWidth +: writeInterfaceWidth] = in_data;
                    mask_d = '0;
                    mask_d[in_word] = 1'b1;
                    state_d = (&mask_d) ? WRITE : FILL;
                end
            end
            FILL: begin
                in_ready = !in_valid || same_line;
                if (in_valid && same_line) begin
                    data_d[int'(in_word)*writeInterfaceWidth +: writeInterfaceWidth] = in_data;
                    mask_d[in_word] = 1'b1;
                end
                if ((&mask_d) || flush || (in_valid && !same_line) || hazard)
                    state_d = WRITE;
            end
            WRITE: begin
                if (!rd_grant) begin
                    sram_en    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = line_q;
                    sram_wmask = mask_q;
                    mask_d     = '0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_grant) begin
            sram_en   = 1'b1;
            sram_we   = 1'b0;
            sram_addr = rd_addr;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            line_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_act_line_writer.sv
// Directed per-cycle vector bench for act_line_writer with default parameters
// (4 words per line, 14-bit line address).
module tb_act_line_writer;

    logic          clk;
    logic          nrst;
    logic [15:0]   in_addr;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          rd_req;
    logic [13:0]   rd_addr;
    logic          rd_grant;
    logic          sram_en;
    logic          sram_we;
    logic [13:0]   sram_addr;
    logic [127:0]  sram_wdata;
    logic [3:0]    sram_wmask;
    logic          busy;

    int checks = 0;
    int errors = 0;

    act_line_writer #(
        .writeInterfaceWidth(32),
        .writeAddrWidth(16),
        .sramDataWidth(128),
        .sramAddrWidth(14)
    ) dut (
        .clk(clk), .nrst(nrst),
        .in_addr(in_addr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst_n;
        logic          vld;
        logic [15:0]   addr;
        logic [31:0]   data;
        logic          fl;
        logic          rq;
        logic [13:0]   raddr;
        logic          e_rdy;
        logic          e_gnt;
        logic          e_en;
        logic          e_we;
        logic [13:0]   e_saddr;
        logic [3:0]    e_mask;
        logic [127:0]  e_wdata;
        logic          e_busy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002, C = 32'hC0C0_0003;
    localparam logic [31:0] D = 32'hD0D0_0004, E = 32'hE0E0_0005, F = 32'hF0F0_0006;
    localparam logic [31:0] G = 32'h1234_5678, X = 32'hDEAD_BEEF, Y = 32'hCAFE_F00D;
    localparam logic [31:0] Z = 32'h0;

    function automatic vec_t mk(logic rst_n, logic vld, logic [15:0] addr, logic [31:0] data,
                                logic fl, logic rq, logic [13:0] raddr,
                                logic e_rdy, logic e_gnt, logic e_en, logic e_we,
                                logic [13:0] e_saddr, logic [3:0] e_mask,
                                logic [127:0] e_wdata, logic e_busy);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.addr = addr; v.data = data;
        v.fl = fl; v.rq = rq; v.raddr = raddr;
        v.e_rdy = e_rdy; v.e_gnt = e_gnt; v.e_en = e_en; v.e_we = e_we;
        v.e_saddr = e_saddr; v.e_mask = e_mask; v.e_wdata = e_wdata; v.e_busy = e_busy;
        return v;
    endfunction

    function automatic logic [127:0] expand(logic [3:0] m);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = {32{m[i]}};
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        nrst = 1'b0; in_addr = '0; in_data = '0; in_valid = 1'b0;
        flush = 1'b0; rd_req = 1'b0; rd_addr = '0;

        // rst vld addr data fl rq raddr | rdy gnt en we saddr mask wdata busy
        vecs.push_back(mk(0,0,16'h00,Z,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 0 reset
        vecs.push_back(mk(1,1,16'h10,A,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 1 full line
        vecs.push_back(mk(1,1,16'h11,B,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,1,16'h12,C,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,1,16'h13,D,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 0,0,1,1,14'h4,4'hF,{D,C,B,A},1));    // 5 write
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));
        vecs.push_back(mk(1,1,16'h10,A,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 7 line change
        vecs.push_back(mk(1,1,16'h11,B,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,1,16'h20,E,0,0,14'h0, 0,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,1,16'h20,E,0,0,14'h0, 0,0,1,1,14'h4,4'h3,{Z,Z,B,A},1));
        vecs.push_back(mk(1,1,16'h20,E,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 11 accepted
        vecs.push_back(mk(1,0,16'h00,Z,1,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 0,0,1,1,14'h8,4'h1,{Z,Z,Z,E},1));
        vecs.push_back(mk(1,1,16'h10,F,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 14 hazard
        vecs.push_back(mk(1,0,16'h00,Z,0,1,14'h4, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,1,14'h4, 0,0,1,1,14'h4,4'h1,{Z,Z,Z,F},1));
        vecs.push_back(mk(1,0,16'h00,Z,0,1,14'h4, 1,1,1,0,14'h4,4'h0,'0,0));
        vecs.push_back(mk(1,1,16'h16,G,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 18 read priority
        vecs.push_back(mk(1,0,16'h00,Z,1,1,14'h9, 1,1,1,0,14'h9,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,1,14'h9, 0,1,1,0,14'h9,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,1,14'h9, 0,1,1,0,14'h9,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,1,14'h9, 0,1,1,0,14'h9,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 0,0,1,1,14'h5,4'h4,{Z,G,Z,Z},1));
        vecs.push_back(mk(1,1,16'h12,X,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 24 overwrite
        vecs.push_back(mk(1,1,16'h12,Y,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,1,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 0,0,1,1,14'h4,4'h4,{Z,Y,Z,Z},1));
        vecs.push_back(mk(1,0,16'h00,Z,1,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 28 idle flush
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));
        vecs.push_back(mk(1,1,16'h10,A,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));            // 30 reset mid-FILL
        vecs.push_back(mk(1,1,16'h11,B,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(0,0,16'h00,Z,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));
        vecs.push_back(mk(1,0,16'h00,Z,1,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));
        vecs.push_back(mk(1,1,16'h13,D,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));
        vecs.push_back(mk(1,0,16'h00,Z,1,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,1));
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 0,0,1,1,14'h4,4'h8,{D,Z,Z,Z},1));
        vecs.push_back(mk(1,0,16'h00,Z,0,0,14'h0, 1,0,0,0,14'h0,4'h0,'0,0));

        foreach (vecs[i]) begin
            @(negedge clk);
            nrst = vecs[i].rst_n; in_valid = vecs[i].vld; in_addr = vecs[i].addr;
            in_data = vecs[i].data; flush = vecs[i].fl; rd_req = vecs[i].rq; rd_addr = vecs[i].raddr;
            #1;
            chk("in_ready", i, 128'(in_ready), 128'(vecs[i].e_rdy));
            chk("rd_grant", i, 128'(rd_grant), 128'(vecs[i].e_gnt));
            chk("sram_en", i, 128'(sram_en), 128'(vecs[i].e_en));
            chk("sram_we", i, 128'(sram_we), 128'(vecs[i].e_we));
            chk("sram_wmask", i, 128'(sram_wmask), 128'(vecs[i].e_mask));
            chk("busy", i, 128'(busy), 128'(vecs[i].e_busy));
            if (vecs[i].e_en)
                chk("sram_addr", i, 128'(sram_addr), 128'(vecs[i].e_saddr));
            if (vecs[i].e_we)
                chk("sram_wdata", i, sram_wdata & expand(vecs[i].e_mask),
                    vecs[i].e_wdata & expand(vecs[i].e_mask));
        end

        // Reset asserted while a write is pending in WRITE: nothing may reach SRAM.
        @(negedge clk);
        in_valid = 1'b1; in_addr = 16'h15; in_data = G; flush = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("mw_we_pending", 100, 128'(sram_we), 128'(1'b1));
        nrst = 1'b0;
        #1;
        chk("mw_en_rst", 101, 128'(sram_en), 128'(1'b0));
        chk("mw_busy_rst", 101, 128'(busy), 128'(1'b0));
        chk("mw_rdy_rst", 101, 128'(in_ready), 128'(1'b1));
        chk("mw_mask_rst", 101, 128'(sram_wmask), 128'(4'h0));
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("mw_en_after", 102, 128'(sram_en), 128'(1'b0));
        chk("mw_busy_after", 102, 128'(busy), 128'(1'b0));
        @(negedge clk);
        #1;
        chk("mw_en_later", 103, 128'(sram_en), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
